// File: rtl/serial_adder_acc.sv
// Digit-serial adder/subtractor with accumulate mode and start/busy/done handshake.
// Each enabled RUN cycle adds DIGIT bits; the registered carry ripples between digits.
module serial_adder_acc #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic             sub,
  input  logic             acc_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_opx, r_opy, r_res, r_sum;
  logic             r_carry, r_cout, r_ovf;
  logic [CW-1:0]    r_cnt;

  logic             w_accept, w_last, w_cmsb;
  logic [DIGIT:0]   w_dsum;
  logic [WIDTH-1:0] w_res_next;

  assign w_accept = ena && start && (r_state != S_RUN);
  assign w_last   = (r_state == S_RUN) && (r_cnt == CW'(N - 1));
  assign w_dsum   = {1'b0, r_opx[DIGIT-1:0]} + {1'b0, r_opy[DIGIT-1:0]}
                  + {{DIGIT{1'b0}}, r_carry};
  // Carry into the top bit of this digit, recovered from its sum and operand bits.
  assign w_cmsb   = w_dsum[DIGIT-1] ^ r_opx[DIGIT-1] ^ r_opy[DIGIT-1];
  assign w_res_next = (r_res >> DIGIT) | (WIDTH'(w_dsum[DIGIT-1:0]) << (WIDTH - DIGIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else if (ena) r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opx   <= '0;
      r_opy   <= '0;
      r_res   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else if (ena) begin
      if (w_accept) begin
        r_opx   <= acc_mode ? r_sum : a;
        r_opy   <= sub ? ~b : b;
        r_carry <= sub;
        r_cnt   <= '0;
      end else if (r_state == S_RUN) begin
        r_opx   <= r_opx >> DIGIT;
        r_opy   <= r_opy >> DIGIT;
        r_res   <= w_res_next;
        r_carry <= w_dsum[DIGIT];
        r_cnt   <= r_cnt + CW'(1);
        if (w_last) begin
          r_sum  <= w_res_next;
          r_cout <= w_dsum[DIGIT];
          r_ovf  <= w_cmsb ^ w_dsum[DIGIT];
        end
      end
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;
endmodule

// File: tb/tb_serial_adder_acc.sv
// Self-checking bench for serial_adder_acc: vector table, corner sequences, random ops vs model.
module tb_serial_adder_acc;
  logic       clk = 1'b0, rst_n = 1'b0, ena = 1'b1, start = 1'b0, sub = 1'b0, acc_mode = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       busy, done, cout, ovf;
  logic [7:0] sum;
  logic       busy4, done4, cout4, ovf4;
  logic [7:0] sum4;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_adder_acc #(.WIDTH(8), .DIGIT(1)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .sub(sub), .acc_mode(acc_mode),
    .a(a), .b(b), .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf));
  serial_adder_acc #(.WIDTH(8), .DIGIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .sub(sub), .acc_mode(acc_mode),
    .a(a), .b(b), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4));
  serial_adder_acc #(.WIDTH(8), .DIGIT(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .sub(sub), .acc_mode(acc_mode),
    .a(a), .b(b), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8));

  typedef struct {
    logic [7:0] a, b;
    logic       sub;
    logic [7:0] e_sum;
    logic       e_cout, e_ovf;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ena = 1'b1; start = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  // Reference: whole-word arithmetic; cout from the 9-bit unsigned result, ovf from signed range.
  task automatic model(input logic [7:0] x, input logic [7:0] y, input logic s,
                       output logic [7:0] r, output logic c, output logic v);
    int ux, uy, full, sx, sy, sr;
    ux = int'(x); uy = int'(y);
    sx = int'($signed(x)); sy = int'($signed(y));
    full = s ? (ux - uy + 256) : (ux + uy);
    sr   = s ? (sx - sy) : (sx + sy);
    r = full[7:0];
    c = full[8];
    v = (sr > 127) || (sr < -128);
  endtask

  // Pulse start, then wait (bounded) for done; lat counts steps from start assertion.
  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic isub,
                        input logic iacc, input logic noise, input int stall_at,
                        output int lat, output int nbusy);
    a = ia; b = ib; sub = isub; acc_mode = iacc; start = 1'b1;
    nbusy = 0;
    step();
    start = 1'b0; lat = 1;
    a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom); acc_mode = 1'($urandom);
    while (!done && lat < 64) begin
      if (busy) nbusy++;
      ena   = (stall_at == 0) || !(lat >= stall_at && lat < stall_at + 3);
      start = noise && (lat == 3);
      step();
      lat++;
    end
    ena = 1'b1; start = 1'b0;
    if (!done) chk("done_timeout", 0, 1);
  endtask

  initial begin
    vec_t       vt[8];
    int         lat, nb, l4, l8, l1;
    logic [7:0] msum, x, rs, s4, s8, hold;
    logic       rc, rv, c4, c8, rsub, racc;

    vt[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    vt[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vt[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vt[3] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0};
    vt[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
    vt[5] = '{8'h07, 8'h05, 1'b1, 8'h02, 1'b1, 1'b0};
    vt[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vt[7] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};

    rst_n = 1'b0;
    step();
    chk("rst_sum", int'(sum), 0);
    chk("rst_flags", int'({busy, done, cout, ovf}), 0);
    do_reset();

    for (int i = 0; i < 8; i++) begin
      run_op(vt[i].a, vt[i].b, vt[i].sub, 1'b0, 1'b0, 0, lat, nb);
      chk($sformatf("vec%0d_sum", i), int'(sum), int'(vt[i].e_sum));
      chk($sformatf("vec%0d_cout", i), int'(cout), int'(vt[i].e_cout));
      chk($sformatf("vec%0d_ovf", i), int'(ovf), int'(vt[i].e_ovf));
      chk($sformatf("vec%0d_lat", i), lat, 9);
      chk($sformatf("vec%0d_busy", i), nb, 8);
      step();
      chk($sformatf("vec%0d_done_pulse", i), int'({done, busy}), 0);
    end

    // Accumulate, back-to-back, with ignored mid-RUN starts.
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      run_op(8'h00, 8'h10, 1'b0, 1'b1, 1'b1, 0, lat, nb);
      chk($sformatf("acc%0d_sum", i), int'(sum), 16 * i);
      chk($sformatf("acc%0d_lat", i), lat, 9);
    end
    step();

    // ena low for three cycles mid-RUN, then ena low while in DONE.
    run_op(8'h0F, 8'h01, 1'b0, 1'b0, 1'b0, 4, lat, nb);
    chk("stall_lat", lat, 12);
    chk("stall_sum", int'(sum), 8'h10);
    hold = sum;
    ena = 1'b0;
    step(); step();
    chk("done_held_ena0", int'(done), 1);
    chk("sum_held_ena0", int'(sum), int'(hold));
    ena = 1'b1;
    step();
    chk("done_clears", int'(done), 0);

    // Reset mid-RUN aborts without a done pulse.
    a = 8'h33; b = 8'h44; sub = 1'b0; acc_mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    rst_n = 1'b0;
    #1;
    chk("midrst_outs", int'({sum, busy, done, cout, ovf}), 0);
    step();
    rst_n = 1'b1;
    l1 = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done) l1++;
    end
    chk("midrst_no_done", l1, 0);
    chk("midrst_sum", int'(sum), 0);

    // DIGIT=4 and DIGIT=8 latency and result.
    do_reset();
    a = 8'hA5; b = 8'h5B; sub = 1'b0; acc_mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    l1 = 0; l4 = 0; l8 = 0; s4 = '0; s8 = '0; c4 = 1'b0; c8 = 1'b0;
    for (int t = 2; t <= 12; t++) begin
      step();
      if (done8 && l8 == 0) begin l8 = t; s8 = sum8; c8 = cout8; end
      if (done4 && l4 == 0) begin l4 = t; s4 = sum4; c4 = cout4; end
      if (done && l1 == 0) l1 = t;
    end
    chk("d8_lat", l8, 2);
    chk("d8_res", int'({c8, s8}), 9'h100);
    chk("d4_lat", l4, 3);
    chk("d4_res", int'({c4, s4}), 9'h100);
    chk("d1_lat", l1, 9);
    chk("d1_res", int'({cout, sum}), 9'h100);

    // Random operations against the whole-word model.
    do_reset();
    msum = '0;
    for (int i = 0; i < 40; i++) begin
      x    = 8'($urandom);
      rs   = 8'($urandom);
      rsub = 1'($urandom);
      racc = 1'($urandom);
      model(racc ? msum : x, rs, rsub, msum, rc, rv);
      run_op(x, rs, rsub, racc, 1'($urandom), 0, lat, nb);
      chk($sformatf("rnd%0d", i), int'({sum, cout, ovf}), int'({msum, rc, rv}));
      chk($sformatf("rnd%0d_lat", i), lat, 9);
      if ($urandom_range(0, 1) == 1) step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
